regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WEN/RW/busW) between two requesters: the in-order ALU writeback and a long-latency load/multiply unit.
- Load/multiply results are buffered in a small FIFO and drained into idle write-port cycles.
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on RAW hazards against outstanding long-latency results.
- Sits between the writeback stage and register_file.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, 2..8).
- STARVE, 4, consecutive cycles a non-empty FIFO may be blocked by the ALU before the pipeline is frozen.

Ports:
- Clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU writeback request this cycle; cannot be back-pressured except via pipe_stall.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  FIFO not full; transfer occurs when ll_valid && ll_ready.
- ll_rd  in  5  long-latency destination register.
- ll_data  in  32  long-latency result.
- sb_set  in  1  issue stage dispatched a long-latency op this cycle.
- sb_rd  in  5  destination of the dispatched op.
- RX  in  5  issue-stage source register X.
- RY  in  5  issue-stage source register Y.
- hazard  out  1  RX or RY has a pending long-latency write.
- pipe_stall  out  1  freeze the ALU pipeline; registered.
- WEN  out  1  register-file write enable; registered.
- RW  out  5  register-file write address; registered.
- busW  out  32  register-file write data; registered.

Behaviour:
- Reset, asynchronous: WEN=0, RW=0, busW=0, pipe_stall=0, FIFO empty, all pending bits 0, starve counter 0. ll_ready=1 and hazard=0 follow combinationally from that state.
- Write selection, evaluated each cycle:
  - alu_valid && !pipe_stall: ALU wins.
  - else FIFO non-empty: pop the FIFO head.
  - else: no write.
- Selected write appears on WEN/RW/busW at the next rising edge (latency 1).
- Writes with rd==0 are dropped: WEN=0. A dropped FIFO entry is still popped.
- FIFO:
  - Push on ll_valid && ll_ready; pop on grant.
  - Push and pop in the same cycle are both allowed; on a full FIFO, push+pop is not possible since ll_ready=0.
  - Read/write pointers wrap modulo DEPTH; count is held in log2(DEPTH)+1 bits.
- Starvation guard:
  - Counter increments each cycle FIFO is non-empty and the ALU wins; clears on any FIFO pop or when the FIFO is empty.
  - When the counter reaches STARVE, pipe_stall=1 next cycle.
  - pipe_stall stays 1 until the FIFO is empty, then drops the following cycle.
  - While pipe_stall=1, alu_valid is ignored; the pipeline holds it and re-presents it.
- Scoreboard, pending[31:0]:
  - sb_set && sb_rd!=0 sets pending[sb_rd].
  - A FIFO pop with rd!=0 clears pending[rd].
  - Set and clear of the same register in one cycle: set wins (the newer op is outstanding).
  - pending[0] is always 0.
- hazard (combinational) = (RX!=0 && pending[RX]) || (RY!=0 && pending[RY]), using the registered pending state. A result written this cycle is covered by register_file's write bypass.
- Reset mid-operation: FIFO contents and pending bits are discarded; the in-flight WEN is forced to 0 immediately.

Test Plan:
- Reset then idle -> WEN=0, RW=0, busW=0, ll_ready=1, hazard=0, pipe_stall=0.
- alu_valid, alu_rd=5, alu_data=0x12345678 in cycle 0 -> WEN=1, RW=5, busW=0x12345678 after edge 1; no write when alu_rd=0.
- sb_set sb_rd=7; RX=7 -> hazard=1. Then ll push rd=7 data=0xA5A5A5A5 with ALU idle -> write RW=7 one cycle after pop; pending[7]=0; hazard=0.
- ll_valid with alu_valid held high every cycle, DEPTH=2:
  - two pushes -> ll_ready=0.
  - pipe_stall=1 STARVE+1 cycles after the FIFO first became non-empty.
  - both entries drained in order.
  - pipe_stall=0 one cycle after empty.
- Same-cycle sb_set rd=9 and FIFO pop of rd=9 -> pending[9] remains 1 and hazard stays 1 for RX=9.
- Assert rst asynchronously mid-clock with FIFO holding 1 entry and WEN=1 -> WEN drops immediately; after release the FIFO is empty and no write occurs.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// The in-order ALU writeback and a buffered long-latency (load/multiply)
// result stream share one write port. A pending-write scoreboard flags
// RAW hazards against outstanding long-latency destinations.
module regfile_wb_arbiter #(
   parameter int DEPTH  = 2,
   parameter int STARVE = 4
) (
   input  logic        Clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ll_valid,
   output logic        ll_ready,
   input  logic [4:0]  ll_rd,
   input  logic [31:0] ll_data,
   input  logic        sb_set,
   input  logic [4:0]  sb_rd,
   input  logic [4:0]  RX,
   input  logic [4:0]  RY,
   output logic        hazard,
   output logic        pipe_stall,
   output logic        WEN,
   output logic [4:0]  RW,
   output logic [31:0] busW
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE + 1);

   logic [4:0]    fifo_rd_q   [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [AW-1:0] rptr_q, wptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          stall_q, stall_d;
   logic [31:0]   pend_q, pend_d;
   logic          wen_q, wen_d;
   logic [4:0]    rw_q, rw_d;
   logic [31:0]   bus_q, bus_d;

   logic          empty, full, push, pop, grant_alu;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;

   assign WEN        = wen_q;
   assign RW         = rw_q;
   assign busW       = bus_q;
   assign pipe_stall = stall_q;

   // Arbitration, FIFO bookkeeping, starvation guard and scoreboard next state
   always_comb begin
      empty     = (cnt_q == '0);
      full      = (cnt_q == CW'(DEPTH));
      ll_ready  = !full;
      push      = ll_valid && !full;
      grant_alu = alu_valid && !stall_q;
      pop       = !grant_alu && !empty;
      head_rd   = fifo_rd_q[rptr_q];
      head_data = fifo_data_q[rptr_q];

      // A destination of r0 is never written; the FIFO entry is still consumed.
      wen_d = 1'b0;
      rw_d  = rw_q;
      bus_d = bus_q;
      if (grant_alu) begin
         wen_d = (alu_rd != 5'd0);
         rw_d  = alu_rd;
         bus_d = alu_data;
      end else if (pop) begin
         wen_d = (head_rd != 5'd0);
         rw_d  = head_rd;
         bus_d = head_data;
      end

      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end

      // Count cycles the ALU keeps a non-empty FIFO from draining; saturate.
      starve_d = starve_q;
      if (empty || pop) begin
         starve_d = '0;
      end else if (grant_alu && (starve_q != SW'(STARVE))) begin
         starve_d = starve_q + SW'(1);
      end

      // Once frozen, the pipeline stays frozen until the FIFO has drained.
      if (stall_q) begin
         stall_d = !empty;
      end else begin
         stall_d = (starve_q >= SW'(STARVE));
      end

      // Clear first so that a same-cycle set (newer op) takes priority.
      pend_d = pend_q;
      if (pop && (head_rd != 5'd0)) begin
         pend_d[head_rd] = 1'b0;
      end
      if (sb_set && (sb_rd != 5'd0)) begin
         pend_d[sb_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;

      hazard = ((RX != 5'd0) && pend_q[RX]) || ((RY != 5'd0) && pend_q[RY]);
   end

   // Control state and registered write-port outputs
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         rptr_q   <= '0;
         wptr_q   <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         pend_q   <= '0;
         wen_q    <= 1'b0;
         rw_q     <= '0;
         bus_q    <= '0;
      end else begin
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
         pend_q   <= pend_d;
         wen_q    <= wen_d;
         rw_q     <= rw_d;
         bus_q    <= bus_d;
      end
   end

   // FIFO storage; validity is tracked by the pointers and count alone
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_rd_q[wptr_q]   <= ll_rd;
         fifo_data_q[wptr_q] <= ll_data;
      end
   end

endmodule
